// File: rtl/pc_sequencer.sv
// pc_sequencer: multi-cycle FETCH/DECODE/EXEC/UPDATE sequencer owning the 16-bit PC and IR.
// Ports: clk, reset_n (async, active-low); instr_req/instr_addr/instr_ack/instr_data fetch
//   handshake; ir; imm displacement/target; flags (Z=flags[6], L=flags[7]); ex_start/ex_done
//   execute handshake; halt; pc; state (debug).
//   Macro PC_SEQ_LINK_EN adds link_we/link_data, written on AL-condition jumps and branches.
module pc_sequencer (
  input  logic        clk,
  input  logic        reset_n,
  output logic        instr_req,
  output logic [15:0] instr_addr,
  input  logic        instr_ack,
  input  logic [15:0] instr_data,
  output logic [15:0] ir,
  input  logic [15:0] imm,
  input  logic [7:0]  flags,
  output logic        ex_start,
  input  logic        ex_done,
  input  logic        halt,
  output logic [15:0] pc,
  output logic [2:0]  state
`ifdef PC_SEQ_LINK_EN
  ,
  output logic        link_we,
  output logic [15:0] link_data
`endif
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_UPDATE = 3'd3,
    S_HALT   = 3'd4
  } state_e;

  localparam logic [3:0] T_JMP = 4'b1000;
  localparam logic [3:0] T_BR  = 4'b1100;
  localparam logic [3:0] C_EQ  = 4'b0000;
  localparam logic [3:0] C_NE  = 4'b0001;
  localparam logic [3:0] C_GT  = 4'b0110;
  localparam logic [3:0] C_LE  = 4'b0111;
  localparam logic [3:0] C_AL  = 4'b1110;

  state_e      state_q;
  logic [15:0] pc_q;
  logic [15:0] ir_q;
  logic [15:0] npc_q;
  logic        ex_start_q;
`ifdef PC_SEQ_LINK_EN
  logic        link_we_q;
  logic [15:0] link_data_q;
`endif

  logic [3:0]  typ;
  logic [3:0]  cnd;
  logic        is_jmp;
  logic        is_br;
  logic        is_ctl;
  logic        z;
  logic        l;
  logic        cond_ok;
  logic        taken;
  logic [15:0] pc_inc;
  logic [15:0] target_d;
  logic [15:0] npc_d;

  assign typ    = ir_q[15:12];
  assign cnd    = ir_q[11:8];
  assign is_jmp = (typ == T_JMP);
  assign is_br  = (typ == T_BR);
  assign is_ctl = is_jmp | is_br;
  assign z      = flags[6];
  assign l      = flags[7];

  always_comb begin
    cond_ok = 1'b0;
    unique case (1'b1)
      (cnd == C_EQ): cond_ok = z;
      (cnd == C_NE): cond_ok = ~z;
      (cnd == C_GT): cond_ok = ~z & ~l;
      (cnd == C_LE): cond_ok = z | l;
      (cnd == C_AL): cond_ok = 1'b1;
      default:       cond_ok = 1'b0;
    endcase
  end

  assign taken    = is_ctl & cond_ok;
  assign pc_inc   = pc_q + 16'd1;
  assign target_d = is_jmp ? imm : (pc_q + imm);
  assign npc_d    = taken ? target_d : pc_inc;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_FETCH;
      pc_q        <= 16'h0000;
      ir_q        <= 16'h0000;
      npc_q       <= 16'h0000;
      ex_start_q  <= 1'b0;
`ifdef PC_SEQ_LINK_EN
      link_we_q   <= 1'b0;
      link_data_q <= 16'h0000;
`endif
    end else begin
      // Pulses default low; DECODE raises ex_start for the first EXEC cycle.
      ex_start_q <= 1'b0;
`ifdef PC_SEQ_LINK_EN
      link_we_q  <= 1'b0;
`endif
      case (state_q)
        S_FETCH: begin
          if (instr_ack) begin
            ir_q    <= instr_data;
            state_q <= S_DECODE;
          end
        end
        S_DECODE: begin
          ex_start_q <= ~is_ctl;
          state_q    <= S_EXEC;
        end
        S_EXEC: begin
          if (is_ctl) begin
            npc_q   <= npc_d;
            state_q <= S_UPDATE;
`ifdef PC_SEQ_LINK_EN
            if (taken && (cnd == C_AL)) begin
              link_we_q   <= 1'b1;
              link_data_q <= pc_inc;
            end
`endif
          end else if (ex_done) begin
            npc_q   <= pc_inc;
            state_q <= S_UPDATE;
          end
        end
        S_UPDATE: begin
          pc_q    <= npc_q;
          state_q <= halt ? S_HALT : S_FETCH;
        end
        S_HALT: begin
          if (!halt) state_q <= S_FETCH;
        end
        default: state_q <= S_FETCH;
      endcase
    end
  end

  assign instr_req  = (state_q == S_FETCH);
  assign instr_addr = pc_q;
  assign ir         = ir_q;
  assign ex_start   = ex_start_q;
  assign pc         = pc_q;
  assign state      = state_q;
`ifdef PC_SEQ_LINK_EN
  assign link_we    = link_we_q;
  assign link_data  = link_data_q;
`endif

  // Low IR byte and non-Z/L flag bits belong to the decoder/ALU.
  logic unused_bits;
  assign unused_bits = ^{ir_q[7:0], flags[5:0]};

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed and randomized checks of pc_sequencer against a
// per-instruction reference model of next PC, condition decode and cycle timing.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        instr_req;
  logic [15:0] instr_addr;
  logic        instr_ack;
  logic [15:0] instr_data;
  logic [15:0] ir;
  logic [15:0] imm;
  logic [7:0]  flags;
  logic        ex_start;
  logic        ex_done;
  logic        halt;
  logic [15:0] pc;
  logic [2:0]  state;
`ifdef PC_SEQ_LINK_EN
  logic        link_we;
  logic [15:0] link_data;
`endif

  int tests = 0;
  int fails = 0;
  logic [15:0] pc_m;

  always #5 clk = ~clk;

  pc_sequencer dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .instr_req  (instr_req),
    .instr_addr (instr_addr),
    .instr_ack  (instr_ack),
    .instr_data (instr_data),
    .ir         (ir),
    .imm        (imm),
    .flags      (flags),
    .ex_start   (ex_start),
    .ex_done    (ex_done),
    .halt       (halt),
    .pc         (pc),
    .state      (state)
`ifdef PC_SEQ_LINK_EN
    ,
    .link_we    (link_we),
    .link_data  (link_data)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit model_taken(input logic [3:0] c, input bit zf,
                                     input bit lf);
    case (c)
      4'h0:    return zf;
      4'h1:    return !zf;
      4'h6:    return !zf && !lf;
      4'h7:    return zf || lf;
      4'hE:    return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Runs one instruction from FETCH back to FETCH, checking every cycle.
  task automatic run_instr(input logic [15:0] w, input logic [15:0] im,
                           input logic [7:0] fl, input int fw, input int ew,
                           input int hc, input bit rst_exec);
    bit ctl, tk, al;
    logic [15:0] nx, lk;
    ctl = (w[15:12] == 4'h8) || (w[15:12] == 4'hC);
    tk  = ctl && model_taken(w[11:8], fl[6], fl[7]);
    al  = tk && (w[11:8] == 4'hE);
    lk  = pc_m + 16'd1;
    if (!tk) nx = pc_m + 16'd1;
    else if (w[15:12] == 4'h8) nx = im;
    else nx = pc_m + im;
    for (int i = 0; i < fw; i++) begin
      chk("fetch_wait_state", state, 0);
      chk("fetch_wait_req", instr_req, 1);
      instr_ack = 0; instr_data = 16'($urandom);
      flags = 8'($urandom); ex_done = 1'($urandom);
      @(negedge clk);
    end
    chk("fetch_state", state, 0);
    chk("fetch_addr", instr_addr, pc_m);
    instr_ack = 1; instr_data = w; flags = ~fl;
    imm = 16'($urandom); ex_done = 1'($urandom); halt = (hc > 0);
    @(negedge clk);
    chk("decode_state", state, 1);
    chk("ir_load", ir, w);
    chk("decode_no_req", instr_req, 0);
    chk("decode_no_start", ex_start, 0);
    instr_ack = 1'($urandom); instr_data = 16'($urandom);
    flags = ~fl; ex_done = 1'($urandom);
    @(negedge clk);
    chk("exec_state", state, 2);
    chk("ex_start", ex_start, !ctl);
    flags = fl; imm = im; instr_ack = 1'($urandom);
    if (rst_exec) begin
      ex_done = 0;
      #2 reset_n = 0;
      #1;
      chk("rst_state", state, 0);
      chk("rst_pc", pc, 0);
      chk("rst_ir", ir, 0);
      chk("rst_ex_start", ex_start, 0);
      chk("rst_req", instr_req, 1);
`ifdef PC_SEQ_LINK_EN
      chk("rst_link_we", link_we, 0);
`endif
      @(negedge clk);
      reset_n = 1; ex_done = 1; instr_ack = 0;
      pc_m = 16'h0000;
      @(negedge clk);
      chk("late_done_ignored", state, 0);
      chk("post_rst_pc", pc, 0);
      ex_done = 0;
      return;
    end
    if (!ctl) begin
      for (int i = 0; i < ew; i++) begin
        ex_done = 0;
        @(negedge clk);
        chk("exec_wait_state", state, 2);
        chk("ex_start_once", ex_start, 0);
        instr_ack = 1'($urandom);
      end
    end
    ex_done = ctl ? 1'($urandom) : 1'b1;
    @(negedge clk);
    chk("update_state", state, 3);
    chk("update_pc_old", pc, pc_m);
`ifdef PC_SEQ_LINK_EN
    chk("link_we", link_we, al);
    if (al) chk("link_data", link_data, lk);
`else
    if (al) chk("al_target", nx, w[15:12] == 4'h8 ? im : 16'(pc_m + im));
`endif
    flags = 8'($urandom); imm = 16'($urandom);
    ex_done = 1'($urandom); instr_ack = 0;
    @(negedge clk);
    pc_m = nx;
    if (hc > 0) begin
      for (int i = 0; i < hc; i++) begin
        chk("halt_state", state, 4);
        chk("halt_pc", pc, nx);
        chk("halt_ir", ir, w);
        instr_ack = 1'($urandom);
        @(negedge clk);
      end
      halt = 0; instr_ack = 0;
      @(negedge clk);
    end
    chk("next_pc", pc, nx);
    chk("back_fetch", state, 0);
  endtask

  initial begin
    logic [3:0] typ, cnd;
    logic [15:0] w;
    reset_n = 0; instr_ack = 0; instr_data = 0; imm = 0;
    flags = 0; ex_done = 0; halt = 0; pc_m = 0;
    #1;
    chk("reset_state", state, 0);
    chk("reset_pc", pc, 0);
    chk("reset_ir", ir, 0);
    chk("reset_req", instr_req, 1);
    chk("reset_ex_start", ex_start, 0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1;
    run_instr(16'h0123, 16'h0000, 8'h00, 0, 0, 0, 0);
    run_instr(16'h1234, 16'h0000, 8'h00, 0, 3, 0, 0);
    run_instr(16'h0001, 16'h0000, 8'h00, 0, 0, 0, 1);
    run_instr(16'h0123, 16'h0000, 8'h00, 2, 0, 0, 0);
    run_instr(16'h8000, 16'h0040, 8'h40, 0, 0, 0, 0);
    run_instr(16'h8000, 16'h0040, 8'h00, 0, 0, 0, 0);
    run_instr(16'h8E00, 16'hFFF0, 8'h00, 0, 0, 0, 0);
    run_instr(16'hC100, 16'h0020, 8'h00, 0, 0, 0, 0);
    run_instr(16'h8E00, 16'hFFFF, 8'h40, 0, 0, 0, 0);
    run_instr(16'h2345, 16'h0000, 8'h00, 1, 1, 0, 0);
    run_instr(16'hC600, 16'h0005, 8'h00, 0, 0, 0, 0);
    run_instr(16'hC700, 16'h0005, 8'h00, 0, 0, 0, 0);
    run_instr(16'hC700, 16'h0005, 8'h80, 0, 0, 0, 0);
    run_instr(16'hC300, 16'h0005, 8'hC0, 0, 0, 0, 0);
    run_instr(16'h8E00, 16'h0005, 8'h00, 0, 0, 0, 0);
    run_instr(16'h8E00, 16'h0100, 8'h00, 0, 0, 0, 0);
    run_instr(16'h3333, 16'h0000, 8'h00, 0, 0, 10, 0);
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 2))
        0: typ = 4'h8;
        1: typ = 4'hC;
        default: typ = 4'($urandom_range(0, 7));
      endcase
      case ($urandom_range(0, 6))
        0: cnd = 4'h0;
        1: cnd = 4'h1;
        2: cnd = 4'h6;
        3: cnd = 4'h7;
        4: cnd = 4'hE;
        5: cnd = 4'h3;
        default: cnd = 4'($urandom);
      endcase
      w = {typ, cnd, 8'($urandom)};
      run_instr(w, 16'($urandom), 8'($urandom),
                $urandom_range(0, 3), $urandom_range(0, 3),
                ($urandom_range(0, 4) == 0) ? $urandom_range(1, 3) : 0, 0);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Multi-cycle instruction sequencer that owns the 16-bit program counter and steps the CPU through fetch, decode, execute and PC update. It fetches from instruction memory over a req/ack handshake and holds the instruction register. It starts and waits on the execute datapath, then resolves jumps and branches to select the next PC. It sits between instruction memory, the decoder/ALU and the PSR flags register.

## Interface
- No parameters; all widths are fixed at 16-bit datapath and 8-bit flags.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `instr_req`  out  1  instruction fetch request.
- `instr_addr`  out  16  fetch address; always equals `pc`.
- `instr_ack`  in  1  fetch data valid this cycle.
- `instr_data`  in  16  fetched instruction word.
- `ir`  out  16  instruction register.
- `imm`  in  16  sign-extended displacement/target from the decoder, derived from `ir`.
- `flags`  in  8  PSR flags; `flags[6]` is Z and `flags[7]` is L (less-than).
- `ex_start`  out  1  one-cycle pulse that starts a non-control instruction.
- `ex_done`  in  1  execute datapath has finished.
- `halt`  in  1  request to stop before the next fetch.
- `pc`  out  16  program counter.
- `state`  out  3  current FSM state, for debug.

## Operation
- **Opcode fields.** `ir[15:12]` is the type field: 4'b1000 is an absolute jump and 4'b1100 is a PC-relative branch. `ir[11:8]` is the condition.
- **Conditions.**
  - EQ 4'b0000: taken when Z=1.
  - NE 4'b0001: taken when Z=0.
  - GT 4'b0110: taken when Z=0 and L=0.
  - LE 4'b0111: taken when Z=1 or L=1.
  - AL 4'b1110: always taken.
  - Any other code: not taken.
- **Next PC.**
  - Taken jump: `imm`.
  - Taken branch: `pc + imm`, modulo 2^16, with wrap-around permitted.
  - Otherwise: `pc + 1`, modulo 2^16, so 16'hFFFF goes to 16'h0000.
- **States.**
  - FETCH (3'd0): `instr_req`=1. On `instr_ack`=1, load `ir` from `instr_data` and go to DECODE. Otherwise stay.
  - DECODE (3'd1): lasts one cycle, then go to EXEC.
  - EXEC (3'd2), jump or branch: sample `flags` and `imm`, register next PC, then go to UPDATE. `ex_start` is not asserted.
  - EXEC (3'd2), any other instruction: pulse `ex_start` on the first EXEC cycle only. Wait for `ex_done`=1, which may arrive in that same cycle. Then register `pc+1` and go to UPDATE.
  - UPDATE (3'd3): `pc` takes the registered next PC. If `halt`=1, go to HALT; otherwise go to FETCH.
  - HALT (3'd4): `pc` and `ir` are held. When `halt`=0, go to FETCH.
- **Ignored inputs.** `instr_ack` outside FETCH and `ex_done` outside EXEC have no effect.
- **Unused encodings.** State codes 3'd5–3'd7 go to FETCH on the next clock.

## Timing
- **Reset.** On `reset_n`=0, immediately and independent of `clk`:
  - state = FETCH; `pc` = 16'h0000; `ir` = 16'h0000.
  - `ex_start` = 0; internal next-PC register = 16'h0000.
  - `instr_req` = 1 while in reset, because the state is FETCH.
- **Reset mid-operation.** An in-flight fetch or execute is abandoned. A late `instr_ack` or `ex_done` that arrives after release but outside the matching state is ignored.
- **Minimum latency** with zero-wait `instr_ack` and `ex_done`: 4 cycles per instruction (FETCH, DECODE, EXEC, UPDATE). The new `pc` is visible in the cycle after UPDATE, which is the next FETCH.
- **Wait states.** Each FETCH wait cycle and each EXEC wait cycle adds exactly one cycle.
- **Flag sampling.** `flags` are sampled on the EXEC clock edge only. Changes during FETCH or DECODE do not affect the decision.
- **`ex_start`.** High for exactly one cycle per non-control instruction, even if EXEC stretches over many cycles.
- **`halt`.** Sampled only in UPDATE and HALT. Asserting it in other states takes effect at the next UPDATE.

## Configuration
- **`PC_SEQ_LINK_EN`.**
  - Defined: adds outputs `link_we` (1 bit) and `link_data` (16 bits). A taken jump or branch with AL condition writes the return address: `link_we`=1 for the UPDATE cycle with `link_data` = old `pc` + 1. Both outputs reset to 0.
  - Undefined: these ports and their logic are absent. AL behaves identically apart from the link write.

## Test plan
- **Reset and fetch.** Assert `reset_n`=0 mid-EXEC, then release → `pc`=0000, state=FETCH, `instr_req`=1. Ack with 16'h0123 → `ir`=0123 one cycle later.
- **Sequential flow.** Non-control instruction with `ex_done` tied high → `ex_start` pulses once, and `pc` goes 0000→0001 after 4 cycles. Hold `ex_done` low 3 extra cycles → 7 cycles total.
- **Jump.** `ir`=16'h8000 (jump EQ), `imm`=16'h0040. With Z=1 → `pc`=0040. With Z=0 → `pc`=pc+1.
- **Branch wrap.** `pc`=16'hFFF0, `ir`=16'hC100 (branch NE), `imm`=16'h0020, Z=0 → `pc`=16'h0010. Separately, `pc`=16'hFFFF with a non-control instruction → 16'h0000.
- **GT and LE.** With Z=0, L=0: GT is taken and LE is not. With Z=0, L=1: LE is taken. Condition 4'b0011 → not taken.
- **Halt and link.** Hold `halt`=1 → state=HALT and `pc` is held for 10 cycles. Release → FETCH on the next cycle. With `PC_SEQ_LINK_EN` defined, `ir`=16'h8E00 at `pc`=0005 → `link_we`=1 and `link_data`=0006.
